// File: rtl/result_writeback_buffer.sv
// ----------------------------------------------------------------------------
// result_writeback_buffer
//
// Purpose:
//   Drains the N x N result tiles of NUM_PROCESSORS_TO_COLLECT processing
//   units into memory, one processor at a time.  For each processor, N rows
//   of N accumulator values are collected into a local tile buffer, then the
//   tile is streamed out row-major, P values per memory write.  The block
//   accepts one writeback instruction at a time and pulses writeback_done
//   once every processor's tile has been written.
//
// Ports:
//   clk                    : single clock, all state changes on rising edge
//   reset                  : synchronous, active-high
//   instruction_valid      : controller offers a writeback instruction
//   instruction_ready      : high only while idle
//   address_input          : base address of the result region
//   processor_output_valid : per-processor row valid
//   processor_output_ready : per-processor row ready (only the served one)
//   processor_output_data  : one N-value row per processor
//   processor_output_last  : marks the final row of a processor's tile
//   processor_output_id    : processor currently being served
//   memory_write_enable    : write request valid
//   memory_write_ready     : memory accepts the write this cycle
//   memory_address         : address of the first value in memory_data
//   memory_data            : P values for memory_address .. +P-1
//   writeback_done         : one-cycle pulse after the final write
//   protocol_error         : sticky, set on a last/row-count mismatch
// ----------------------------------------------------------------------------
module result_writeback_buffer #(
    parameter int ACC_WIDTH                    = 32,
    parameter int N                            = 4,
    parameter int NUM_PROCESSORS_TO_COLLECT    = 4,
    parameter int PROCESSORS_ID_COUNTER_BITS   = 4,
    parameter int MEMORY_ADDRESS_BITS          = 64,
    parameter int PARALLEL_DATA_STREAMING_SIZE = 4
) (
    input  logic                                                clk,
    input  logic                                                reset,
    input  logic                                                instruction_valid,
    output logic                                                instruction_ready,
    input  logic [MEMORY_ADDRESS_BITS-1:0]                      address_input,
    input  logic [NUM_PROCESSORS_TO_COLLECT-1:0]                processor_output_valid,
    output logic [NUM_PROCESSORS_TO_COLLECT-1:0]                processor_output_ready,
    input  logic [NUM_PROCESSORS_TO_COLLECT-1:0][N-1:0][ACC_WIDTH-1:0] processor_output_data,
    input  logic [NUM_PROCESSORS_TO_COLLECT-1:0]                processor_output_last,
    output logic [PROCESSORS_ID_COUNTER_BITS-1:0]               processor_output_id,
    output logic                                                memory_write_enable,
    input  logic                                                memory_write_ready,
    output logic [MEMORY_ADDRESS_BITS-1:0]                      memory_address,
    output logic [PARALLEL_DATA_STREAMING_SIZE-1:0][ACC_WIDTH-1:0] memory_data,
    output logic                                                writeback_done,
    output logic                                                protocol_error
);

    localparam int P          = PARALLEL_DATA_STREAMING_SIZE;
    localparam int NUM        = NUM_PROCESSORS_TO_COLLECT;
    localparam int NUM_CHUNKS = (N * N) / P;
    localparam int ROW_W      = (N > 1) ? $clog2(N) : 1;
    localparam int CHUNK_W    = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;
    localparam int SEL_W      = (NUM > 1) ? $clog2(NUM) : 1;

    localparam logic [ROW_W-1:0]                      LAST_ROW   = ROW_W'(N - 1);
    localparam logic [CHUNK_W-1:0]                    LAST_CHUNK = CHUNK_W'(NUM_CHUNKS - 1);
    localparam logic [PROCESSORS_ID_COUNTER_BITS-1:0] LAST_ID    = PROCESSORS_ID_COUNTER_BITS'(NUM - 1);

    // A tile must split into a whole number of memory writes; anything else
    // would leave a partial final chunk, so refuse to build.
    generate
        if (((N * N) % PARALLEL_DATA_STREAMING_SIZE) != 0) begin : g_bad_stream_size
            $error("result_writeback_buffer: N*N must be a multiple of PARALLEL_DATA_STREAMING_SIZE");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE,
        COLLECT,
        WRITE
    } state_t;

    state_t state;
    state_t state_next;

    logic [MEMORY_ADDRESS_BITS-1:0]        base_addr;
    logic [PROCESSORS_ID_COUNTER_BITS-1:0] proc_id;
    logic [ROW_W-1:0]                      row_cnt;
    logic [CHUNK_W-1:0]                    chunk_cnt;
    logic                                  done_pulse;
    logic                                  error_flag;

    logic [N-1:0][N-1:0][ACC_WIDTH-1:0]    tile_buf;
    logic [NUM_CHUNKS-1:0][P-1:0][ACC_WIDTH-1:0] chunk_view;

    logic [SEL_W-1:0] id_sel;
    logic             accept_instr;
    logic             row_hs;
    logic             chunk_hs;

    assign id_sel = proc_id[SEL_W-1:0];

    // The tile buffer is laid out row-major, so reinterpreting it as an array
    // of P-wide chunks gives the k-th memory write directly.
    assign chunk_view = tile_buf;

    assign memory_data         = chunk_view[chunk_cnt];
    assign memory_address      = base_addr
                               + (MEMORY_ADDRESS_BITS'(proc_id) * MEMORY_ADDRESS_BITS'(N * N))
                               + (MEMORY_ADDRESS_BITS'(chunk_cnt) * MEMORY_ADDRESS_BITS'(P));
    assign processor_output_id = proc_id;
    assign writeback_done      = done_pulse;
    assign protocol_error      = error_flag;

    // State register.  Reset returns to IDLE, which also drops any pending
    // write because memory_write_enable is only raised in WRITE.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and handshake decode.  Only the processor selected by
    // proc_id ever sees ready, so valids from the others are simply ignored
    // until their turn comes.  A tile closes strictly on the row count, not
    // on the last flag, so a misbehaving producer cannot shorten a tile.
    always_comb begin
        state_next             = state;
        instruction_ready      = 1'b0;
        processor_output_ready = '0;
        memory_write_enable    = 1'b0;
        accept_instr           = 1'b0;
        row_hs                 = 1'b0;
        chunk_hs               = 1'b0;
        case (state)
            IDLE: begin
                instruction_ready = 1'b1;
                if (instruction_valid) begin
                    accept_instr = 1'b1;
                    state_next   = COLLECT;
                end
            end
            COLLECT: begin
                processor_output_ready[id_sel] = 1'b1;
                row_hs = processor_output_valid[id_sel];
                if (row_hs && (row_cnt == LAST_ROW)) begin
                    state_next = WRITE;
                end
            end
            WRITE: begin
                memory_write_enable = 1'b1;
                chunk_hs = memory_write_ready;
                if (chunk_hs && (chunk_cnt == LAST_CHUNK)) begin
                    state_next = (proc_id == LAST_ID) ? IDLE : COLLECT;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Control counters, the sticky error flag and the done pulse.  The done
    // pulse is registered so it coincides with the first IDLE cycle, which is
    // exactly when instruction_ready comes back.
    always_ff @(posedge clk) begin
        if (reset) begin
            base_addr  <= '0;
            proc_id    <= '0;
            row_cnt    <= '0;
            chunk_cnt  <= '0;
            done_pulse <= 1'b0;
            error_flag <= 1'b0;
        end else begin
            done_pulse <= 1'b0;
            if (accept_instr) begin
                base_addr <= address_input;
                proc_id   <= '0;
                row_cnt   <= '0;
                chunk_cnt <= '0;
            end
            if (row_hs) begin
                row_cnt <= (row_cnt == LAST_ROW) ? '0 : row_cnt + 1'b1;
                if (processor_output_last[id_sel] != (row_cnt == LAST_ROW)) begin
                    error_flag <= 1'b1;
                end
            end
            if (chunk_hs) begin
                if (chunk_cnt == LAST_CHUNK) begin
                    chunk_cnt <= '0;
                    row_cnt   <= '0;
                    if (proc_id == LAST_ID) begin
                        proc_id    <= '0;
                        done_pulse <= 1'b1;
                    end else begin
                        proc_id <= proc_id + 1'b1;
                    end
                end else begin
                    chunk_cnt <= chunk_cnt + 1'b1;
                end
            end
        end
    end

    // Tile storage.  No reset is needed: every row is rewritten during
    // COLLECT before the tile is ever streamed out in WRITE.
    always_ff @(posedge clk) begin
        if (row_hs) begin
            tile_buf[row_cnt] <= processor_output_data[id_sel];
        end
    end

endmodule

// File: doc/result_writeback_buffer.md
RESULT_WRITEBACK_BUFFER -- requirements
Module: result_writeback_buffer

Interface
REQ-001 Parameter ACC_WIDTH, 32, width of one accumulated result value.
REQ-002 Parameter N, 4, processing-unit width; each processor result tile is N x N, delivered as N rows of N values.
REQ-003 Parameter NUM_PROCESSORS_TO_COLLECT, 4, processors drained per instruction, IDs 0..NUM-1.
REQ-004 Parameter PROCESSORS_ID_COUNTER_BITS, 4, width of processor ID.
REQ-005 Parameter MEMORY_ADDRESS_BITS, 64, memory address width.
REQ-006 Parameter PARALLEL_DATA_STREAMING_SIZE (P), 4, values written to memory per cycle; N*N % P != 0 SHALL fail elaboration.
REQ-007 clk  input  1  single clock; all state updates on rising edge.
REQ-008 reset  input  1  reset is synchronous and active-high.
REQ-009 instruction_valid  input  1  controller offers writeback instruction.
REQ-010 instruction_ready  output  1  block idle, can accept instruction.
REQ-011 address_input  input  MEMORY_ADDRESS_BITS  base address of result region.
REQ-012 processor_output_valid  input  [NUM]  per-processor row valid.
REQ-013 processor_output_ready  output  [NUM]  per-processor row ready.
REQ-014 processor_output_data  input  [NUM][N] x ACC_WIDTH  one result row per processor.
REQ-015 processor_output_last  input  [NUM]  asserted with final row of a tile.
REQ-016 processor_output_id  output  PROCESSORS_ID_COUNTER_BITS  processor currently served.
REQ-017 memory_write_enable  output  1  write request valid.
REQ-018 memory_write_ready  input  1  memory accepts write this cycle.
REQ-019 memory_address  output  MEMORY_ADDRESS_BITS  address of first value in memory_data.
REQ-020 memory_data  output  [P] x ACC_WIDTH  values written at memory_address .. +P-1.
REQ-021 writeback_done  output  1  one-cycle pulse after final write of an instruction.
REQ-022 protocol_error  output  1  sticky; last/row-count mismatch seen.

Function
REQ-023 FSM states IDLE, COLLECT, WRITE; instruction_ready SHALL be 1 only in IDLE.
REQ-024 IDLE: on instruction_valid && instruction_ready, latch address_input, processor ID counter <= 0, row counter <= 0, go COLLECT.
REQ-025 COLLECT: processor_output_ready[id] = 1 only for id == processor_output_id; all other ready bits 0; valids of other processors ignored.
REQ-026 Each handshake (valid[id] && ready[id]) stores the N-value row at tile buffer row = row counter, row counter += 1.
REQ-027 After row N-1 accepted, go WRITE next cycle; ready SHALL be 0 in WRITE.
REQ-028 last[id] at row N-1 expected; last at any other row, or absent at row N-1, SHALL set protocol_error; tile still closes only after exactly N rows.
REQ-029 WRITE: memory_write_enable = 1; chunk k (0..N*N/P-1) drives buffer values k*P..k*P+P-1, row-major.
REQ-030 memory_address = base + id*N*N + k*P, computed at MEMORY_ADDRESS_BITS width, wrapping modulo 2^MEMORY_ADDRESS_BITS.
REQ-031 Chunk counter advances only when memory_write_ready = 1; address/data held stable while stalled.
REQ-032 Final chunk accepted: if id < NUM-1, id += 1, row counter <= 0, go COLLECT; else go IDLE and pulse writeback_done next cycle.
REQ-033 No overlap: block SHALL NOT accept rows in WRITE or new instruction before returning to IDLE; instruction_ready rises the cycle writeback_done pulses.
REQ-034 Latency: zero-stall single tile, last row handshake at cycle t -> first write at t+1, last write at t+N*N/P.

Reset
REQ-035 reset SHALL force IDLE; instruction_ready=1 from cycle after reset; processor_output_ready all 0, memory_write_enable 0, writeback_done 0, protocol_error 0, processor_output_id 0.
REQ-036 reset mid-operation SHALL discard buffered rows and pending writes; no memory_write_enable in cycle after reset.
REQ-037 Tile buffer contents need no reset; never written to memory before refill.

Verification
REQ-038 N=4,P=4,NUM=4, base 0x1000, all valid held high, ready-memory -> 4 writes per processor at 0x1000+16*id+4k, writeback_done after 16 writes total; data equals rows in order.
REQ-039 memory_write_ready toggling 1,0,0,1 -> address/data stable during stalls; no chunk skipped or duplicated.
REQ-040 processor 2 raises valid while serving processor 0 -> ready[2]=0, its data never accepted until id=2.
REQ-041 last asserted on row 1 of processor 1 -> protocol_error=1 and stays 1; still 4 rows collected for that tile.
REQ-042 reset asserted in WRITE of processor 1 chunk 2 -> next cycle IDLE, memory_write_enable=0, instruction_ready=1.
REQ-043 base 0xFFFF_FFFF_FFFF_FFF8 -> addresses wrap to 0x0 and continue mod 2^64.
